// File: rtl/mac_accumulator_if.sv
// Operand and result handshakes for the streaming MAC stage.
// The producer/consumer side drives master, the MAC takes slave.
interface mac_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_acc,
    input  out_count,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_acc,
    output out_count,
    output out_ovf
  );
endinterface

// File: rtl/mac_accumulator.sv
// Streaming signed MAC: radix-4 Booth product register feeding a
// group accumulator with a one-deep result holding register.
module booth_mul8 (
  input  logic        [7:0]  a,
  input  logic        [7:0]  b,
  output logic signed [15:0] p
);
  logic        [8:0]  bx;
  logic signed [15:0] ax;
  logic signed [15:0] pp;
  logic signed [15:0] sum;

  always_comb begin
    bx  = {b, 1'b0};
    ax  = 16'($signed(a));
    pp  = '0;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      unique case (bx[2*i +: 3])
        3'b001, 3'b010: pp = ax;
        3'b011:         pp = ax <<< 1;
        3'b100:         pp = -(ax <<< 1);
        3'b101, 3'b110: pp = -ax;
        default:        pp = '0;
      endcase
      sum = sum + (pp <<< (2 * i));
    end
    p = sum;
  end
endmodule

module mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  mac_accumulator_if.slave bus
);
  logic signed [15:0] prod;

  logic               p_valid, p_valid_d;
  logic signed [15:0] p_data, p_data_d;
  logic               p_last, p_last_d;

  logic [ACC_W-1:0]   acc, acc_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               ovf, ovf_d;

  logic               res_valid, res_valid_d;
  logic [ACC_W-1:0]   res_acc, res_acc_d;
  logic [CNT_W-1:0]   res_cnt, res_cnt_d;
  logic               res_ovf, res_ovf_d;

  logic               consume;
  logic               rdy;
  logic               accept;
  logic [ACC_W-1:0]   p_ext;
  logic [ACC_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt_inc;
  logic               add_ovf;

  booth_mul8 u_mul (
    .a (bus.in_a),
    .b (bus.in_b),
    .p (prod)
  );

  // A last product may only move once the result slot is free or
  // being drained on this same edge.
  assign consume = p_valid &&
                   (!p_last || !res_valid || bus.out_ready);
  assign rdy     = !rst && (!p_valid || consume);
  assign accept  = bus.in_valid && rdy;

  assign p_ext   = ACC_W'(p_data);
  assign sum     = acc + p_ext;
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc[ACC_W-1]);

  always_comb begin
    p_valid_d   = p_valid;
    p_data_d    = p_data;
    p_last_d    = p_last;
    acc_d       = acc;
    cnt_d       = cnt;
    ovf_d       = ovf;
    res_valid_d = res_valid;
    res_acc_d   = res_acc;
    res_cnt_d   = res_cnt;
    res_ovf_d   = res_ovf;

    if (accept) begin
      p_valid_d = 1'b1;
      p_data_d  = prod;
      p_last_d  = bus.in_last;
    end else if (consume) begin
      p_valid_d = 1'b0;
    end

    if (consume && !p_last) begin
      acc_d = sum;
      cnt_d = cnt_inc;
      ovf_d = ovf | add_ovf;
    end

    if (consume && p_last) begin
      res_valid_d = 1'b1;
      res_acc_d   = sum;
      res_cnt_d   = cnt_inc;
      res_ovf_d   = ovf | add_ovf;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
    end else if (res_valid && bus.out_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid   <= 1'b0;
      p_data    <= '0;
      p_last    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
      res_acc   <= '0;
      res_cnt   <= '0;
      res_ovf   <= 1'b0;
    end else begin
      p_valid   <= p_valid_d;
      p_data    <= p_data_d;
      p_last    <= p_last_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
      ovf       <= ovf_d;
      res_valid <= res_valid_d;
      res_acc   <= res_acc_d;
      res_cnt   <= res_cnt_d;
      res_ovf   <= res_ovf_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = res_valid;
  assign bus.out_acc   = res_acc;
  assign bus.out_count = res_cnt;
  assign bus.out_ovf   = res_ovf;
endmodule
